// File: rtl/approx_fp_arbiter.sv
// Round-robin front end sharing one fixed-latency approximate FP multiply pipe among NUM_REQ requesters.
// Optional result statistics are compiled in with APPROX_FP_STATS_EN.

module approx_fp_rsp_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        cap_en,
  input  logic        drop,
  input  logic [31:0] cap_data,
  input  logic        rsp_ready,
  output logic        outstanding,
  output logic        rsp_valid,
  output logic [31:0] rsp_data
);

  // grant/drop/capture/accept never target the same slot in one cycle: one transaction per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid   <= 1'b0;
        outstanding <= 1'b0;
      end
      if (drop)  outstanding <= 1'b0;
      if (grant) outstanding <= 1'b1;
      if (cap_en) begin
        rsp_valid <= 1'b1;
        rsp_data  <= cap_data;
      end
    end
  end

endmodule

module approx_fp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ-1:0][31:0] rsp_data,
  output logic                     dp_in_valid,
  output logic [31:0]              dp_in_a,
  output logic [31:0]              dp_in_b,
  input  logic                     dp_out_valid,
  input  logic [31:0]              dp_out_data,
  output logic                     busy,
  output logic                     err,
  output logic [15:0]              sat_cnt,
  output logic [15:0]              zero_cnt
);

  localparam int TAG_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } opnd_t;

  logic [NUM_REQ-1:0]                outstanding;
  logic [NUM_REQ-1:0]                elig;
  logic [NUM_REQ-1:0]                gnt;
  logic                              gnt_any;
  logic [TAG_W-1:0]                  gnt_idx;
  logic [TAG_W-1:0]                  rr_ptr;
  opnd_t                             dp_in_q;
  // stage 0 is the issue register itself; stage DP_LATENCY lines up with dp_out_valid
  logic [DP_LATENCY:0]               vld_pipe;
  logic [DP_LATENCY:0][TAG_W-1:0]    tag_pipe;
  logic                              head_vld;
  logic [TAG_W-1:0]                  head_tag;
  logic                              cap_hit;
  logic                              miss_hit;

  assign elig = req_valid & ~outstanding;

  always_comb begin : grant_search
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && elig[TAG_W'(j)]) begin
        gnt_any = 1'b1;
        gnt_idx = TAG_W'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // ready is combinational from req_valid, so hold it low while reset is asserted
  assign req_ready = gnt & {NUM_REQ{rst_n}};

  assign head_vld = vld_pipe[DP_LATENCY];
  assign head_tag = tag_pipe[DP_LATENCY];
  assign cap_hit  = head_vld & dp_out_valid;
  assign miss_hit = head_vld & ~dp_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
      tag_pipe <= '0;
      dp_in_q  <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[DP_LATENCY-1:0], gnt_any};
      tag_pipe <= {tag_pipe[DP_LATENCY-1:0], gnt_idx};
      if (gnt_any) begin
        dp_in_q.a <= req_a[gnt_idx];
        dp_in_q.b <= req_b[gnt_idx];
        rr_ptr    <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (head_vld != dp_out_valid) err <= 1'b1;
    end
  end

  assign dp_in_valid = vld_pipe[0];
  assign dp_in_a     = dp_in_q.a;
  assign dp_in_b     = dp_in_q.b;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    approx_fp_rsp_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .grant       (gnt[i]),
      .cap_en      (cap_hit && (head_tag == TAG_W'(i))),
      .drop        (miss_hit && (head_tag == TAG_W'(i))),
      .cap_data    (dp_out_data),
      .rsp_ready   (rsp_ready[i]),
      .outstanding (outstanding[i]),
      .rsp_valid   (rsp_valid[i]),
      .rsp_data    (rsp_data[i])
    );
  end

  assign busy = |outstanding;

`ifdef APPROX_FP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt  <= '0;
      zero_cnt <= '0;
    end else if (cap_hit) begin
      if (dp_out_data[30:23] == 8'hFF && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      if (dp_out_data == 32'h0 && zero_cnt != 16'hFFFF) zero_cnt <= zero_cnt + 16'd1;
    end
  end
`else
  assign sat_cnt  = '0;
  assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_fp_arbiter.sv
// Scoreboard bench for approx_fp_arbiter: a transaction-level model predicts grants and responses,
// a monitor compares them against the DUT every cycle.
module tb_approx_fp_arbiter;

  localparam int N = 4;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N-1:0][31:0] req_a = '0;
  logic [N-1:0][31:0] req_b = '0;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready = '0;
  logic [N-1:0][31:0] rsp_data;
  logic               dp_in_valid;
  logic [31:0]        dp_in_a, dp_in_b;
  logic               dp_out_valid;
  logic [31:0]        dp_out_data;
  logic               busy, err;
  logic [15:0]        sat_cnt, zero_cnt;

  approx_fp_arbiter #(.NUM_REQ(N), .DP_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dp_in_valid(dp_in_valid), .dp_in_a(dp_in_a), .dp_in_b(dp_in_b),
    .dp_out_valid(dp_out_valid), .dp_out_data(dp_out_data),
    .busy(busy), .err(err), .sat_cnt(sat_cnt), .zero_cnt(zero_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] want = '0;
  logic [N-1:0] rdy = '0;
  bit rnd = 0, inject = 0, drop = 0;

  function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ b;
  endfunction

  // external datapath stand-in: fixed latency L from dp_in_valid to dp_out_valid
  logic        dpv [1:L];
  logic [31:0] dpd [1:L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= L; k++) begin dpv[k] <= 1'b0; dpd[k] <= '0; end
    end else begin
      dpv[1] <= dp_in_valid;
      dpd[1] <= dp_fn(dp_in_a, dp_in_b);
      for (int k = 2; k <= L; k++) begin dpv[k] <= dpv[k-1]; dpd[k] <= dpd[k-1]; end
    end
  end
  assign dp_out_valid = (dpv[L] & ~drop) | inject;
  assign dp_out_data  = inject ? 32'h0BAD_0000 : dpd[L];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // driver: operands refresh after each accepted request
  logic [N-1:0] hs_q;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hs_q <= '0;
    else        hs_q <= req_valid & req_ready;

  always begin : drv_p
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs_q[i]) begin req_a[i] = $urandom; req_b[i] = $urandom; end
      req_valid[i] = want[i] & (!rnd | ($urandom_range(3) != 0));
      rsp_ready[i] = rdy[i] & (!rnd | ($urandom_range(2) != 0));
    end
  end

  // reference model: transactions with due cycles, one pending per requester
  typedef struct { int req; int due; logic [31:0] data; } fl_t;
  typedef struct { int due; logic [31:0] data; } ex_t;
  fl_t fl_q[$];
  ex_t exp_q[N][$];
  int  m_ptr = 0;
  bit  m_out[N];
  bit  m_rv[N];
  bit  m_err = 0, m_dpv = 0;
  logic [31:0] m_dpa = '0, m_dpb = '0;
  int  m_sat = 0, m_zero = 0;

  logic [N-1:0] e_ready = '0, e_rv = '0;
  bit  e_busy = 0, e_err = 0, e_dpv = 0;
  logic [31:0] e_dpa = '0, e_dpb = '0;
  int  e_sat = 0, e_zero = 0;

  always begin : model_p
    int g;
    fl_t f;
    ex_t e;
    @(negedge clk); #1;
    if (!rst_n) begin
      m_ptr = 0; m_err = 0; m_dpv = 0; m_dpa = '0; m_dpb = '0; m_sat = 0; m_zero = 0;
      fl_q.delete();
      for (int i = 0; i < N; i++) begin m_out[i] = 0; m_rv[i] = 0; exp_q[i].delete(); end
      e_ready = '0; e_rv = '0; e_busy = 0; e_err = 0; e_dpv = 0; e_dpa = '0; e_dpb = '0;
      e_sat = 0; e_zero = 0;
    end else begin
      e_busy = 0;
      for (int i = 0; i < N; i++) begin e_rv[i] = m_rv[i]; e_busy = e_busy | m_out[i]; end
      e_err = m_err; e_dpv = m_dpv; e_dpa = m_dpa; e_dpb = m_dpb;
`ifdef APPROX_FP_STATS_EN
      e_sat = m_sat; e_zero = m_zero;
`else
      e_sat = 0; e_zero = 0;
`endif
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N] && !m_out[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      for (int i = 0; i < N; i++)
        if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 0; m_out[i] = 0; end
      if (fl_q.size() > 0 && fl_q[0].due == cyc) begin
        f = fl_q.pop_front();
        if (dp_out_valid) begin
          e.due = cyc + 1; e.data = f.data;
          exp_q[f.req].push_back(e);
          m_rv[f.req] = 1;
          if (f.data[30:23] == 8'hFF && m_sat < 65535) m_sat++;
          if (f.data == 32'h0 && m_zero < 65535) m_zero++;
        end else begin
          m_err = 1; m_out[f.req] = 0;
        end
      end else if (dp_out_valid) begin
        m_err = 1;
      end
      m_dpv = (g >= 0);
      if (g >= 0) begin
        m_dpa = req_a[g]; m_dpb = req_b[g];
        m_out[g] = 1; m_ptr = (g + 1) % N;
        f.req = g; f.due = cyc + 1 + L; f.data = dp_fn(req_a[g], req_b[g]);
        fl_q.push_back(f);
      end
    end
  end

  // monitor: per-cycle compare plus response pop on each new rsp_valid
  logic [N-1:0] prv = '0;
  always begin : mon_p
    ex_t x;
    @(negedge clk); #2;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("err", 64'(err), 64'(e_err));
    chk("dp_in_valid", 64'(dp_in_valid), 64'(e_dpv));
    if (e_dpv) begin
      chk("dp_in_a", 64'(dp_in_a), 64'(e_dpa));
      chk("dp_in_b", 64'(dp_in_b), 64'(e_dpb));
    end
    chk("sat_cnt", 64'(sat_cnt), 64'(e_sat));
    chk("zero_cnt", 64'(zero_cnt), 64'(e_zero));
    for (int i = 0; i < N; i++) begin
      if (rst_n && rsp_valid[i] && !prv[i]) begin
        if (exp_q[i].size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: requester %0d got %0h expected none (cycle %0d)", i, rsp_data[i], cyc);
        end else begin
          x = exp_q[i].pop_front();
          chk("rsp_data", 64'(rsp_data[i]), 64'(x.data));
          chk("rsp_latency", 64'(cyc), 64'(x.due));
        end
      end
    end
    prv = rst_n ? rsp_valid : '0;
  end

  task automatic issue_one(input int i, input logic [31:0] a, input logic [31:0] b);
    bit seen;
    seen = 0;
    req_a[i] = a; req_b[i] = b; want[i] = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk); #3;
      if (req_ready[i]) begin seen = 1; want[i] = 1'b0; end
    end
    chk("issue_grant_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 0;
    for (int c = 0; c < 400 && !idle; c++) begin
      @(negedge clk); #3;
      idle = (fl_q.size() == 0);
      for (int i = 0; i < N; i++) if (m_out[i] || m_rv[i]) idle = 0;
    end
    chk(nm, 64'(idle), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_dp_in_valid", 64'(dp_in_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    rdy = '1;

    // single directed request on requester 2
    issue_one(2, 32'h3FC0_0000, 32'h4000_0000);
    @(negedge clk); #3;
    chk("single_dp_in_valid", 64'(dp_in_valid), 64'd1);
    chk("single_dp_in_a", 64'(dp_in_a), 64'h3FC0_0000);
    chk("single_dp_in_b", 64'(dp_in_b), 64'h4000_0000);
    repeat (3) @(negedge clk);
    #3;
    chk("single_rsp_early", 64'(rsp_valid[2]), 64'd0);
    @(negedge clk); #3;
    chk("single_rsp_valid", 64'(rsp_valid[2]), 64'd1);
    chk("single_rsp_data", 64'(rsp_data[2]), 64'h4040_0000);
    wait_idle("idle_after_single");

    // all requesters continuously
    want = '1;
    repeat (40) @(negedge clk);
    #3;
    // requester 1 back-pressures its response
    rdy = 4'b1101;
    repeat (10) @(negedge clk);
    #3;
    rdy = '1;
    repeat (20) @(negedge clk);
    #3;

    // randomized traffic
    rnd = 1;
    for (int c = 0; c < 25; c++) begin
      want = N'($urandom);
      repeat (8) @(negedge clk);
      #3;
    end
    rnd = 0; want = '0; rdy = '1;
    wait_idle("idle_after_random");

    // spurious datapath strobe with an empty tag pipe
    @(negedge clk);
    inject = 1;
    @(negedge clk);
    inject = 0;
    @(negedge clk); #3;
    chk("spurious_err", 64'(err), 64'd1);
    chk("spurious_rsp_valid", 64'(rsp_valid), 64'd0);

    // dropped result releases the requester without a response
    @(negedge clk);
    drop = 1;
    #3;
    issue_one(0, $urandom, $urandom);
    repeat (L + 3) @(negedge clk);
    drop = 0;
    wait_idle("idle_after_drop");
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_err_sticky", 64'(err), 64'd1);

    // asynchronous reset with traffic in flight
    want = '1;
    repeat (6) @(negedge clk);
    #3;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    want = '0;
    #1;
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_dp_in_valid", 64'(dp_in_valid), 64'd0);
    chk("async_rst_dp_in_a", 64'(dp_in_a), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_err", 64'(err), 64'd0);
    chk("async_rst_rsp_data", 64'(rsp_data[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 1) @(negedge clk);
    #3;

    // post-reset traffic, including saturated and zero results
    issue_one(2, 32'h3FC0_0000, 32'h4000_0000);
    issue_one(0, 32'h7FFF_FFFF, 32'h0);
    issue_one(1, 32'h7FFF_FFFF, 32'h0);
    issue_one(3, 32'h0000_0005, 32'h0000_0005);
    wait_idle("idle_after_reset_run");
    chk("post_reset_err", 64'(err), 64'd0);
`ifdef APPROX_FP_STATS_EN
    chk("stats_sat", 64'(sat_cnt), 64'd2);
    chk("stats_zero", 64'(zero_cnt), 64'd1);
`else
    chk("stats_sat_off", 64'(sat_cnt), 64'd0);
    chk("stats_zero_off", 64'(zero_cnt), 64'd0);
`endif
    for (int i = 0; i < N; i++) chk("exp_q_leftover", 64'(exp_q[i].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
